// File: rtl/rand_pkg.sv
// Shared types, defaults and the range-mask helper for the
// bounded random picker.
package rand_pkg;

    localparam int RAND_W    = 16;
    localparam int OUT_W     = 8;
    localparam int MAX_TRIES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Right-fill of (bound-1): smallest 2^k-1 covering every value below bound.
    function automatic logic [31:0] range_mask(input logic [31:0] bound);
        logic [31:0] m;
        m = bound - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/rand_range_picker.sv
// Rejection-sampling picker: maps LFSR words to an unbiased value
// in [0, bound-1], falling back to cand-bound after MAX_TRIES misses.
module rand_range_picker
    import rand_pkg::*;
#(
    parameter int RAND_W    = rand_pkg::RAND_W,
    parameter int OUT_W     = rand_pkg::OUT_W,
    parameter int MAX_TRIES = rand_pkg::MAX_TRIES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              rand_valid,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OUT_W-1:0]  req_bound,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OUT_W-1:0]  rsp_value,
    output logic              rsp_fallback,
    output logic              busy
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    state_t             r_state;
    logic [OUT_W-1:0]   r_bound;
    logic [OUT_W-1:0]   r_mask;
    logic [TRY_W-1:0]   r_try;
    logic [OUT_W-1:0]   r_value;
    logic               r_fallback;
    logic               r_rsp_valid;
    logic               r_req_ready;
    logic               r_busy;

    logic [OUT_W-1:0]   w_req_mask;
    logic [OUT_W-1:0]   w_cand;
    logic [OUT_W-1:0]   w_diff;
    logic               w_hit;
    logic               w_last;
    logic               w_unused;

    assign w_req_mask = OUT_W'(range_mask(32'(req_bound)));
    assign w_cand     = rand_in[OUT_W-1:0] & r_mask;
    assign w_hit      = (w_cand < r_bound);
    assign w_diff     = w_cand - r_bound;
    assign w_last     = (r_try == TRY_W'(MAX_TRIES - 1));
    assign w_unused   = ^rand_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bound     <= '0;
            r_mask      <= '0;
            r_try       <= '0;
            r_value     <= '0;
            r_fallback  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_bound     <= req_bound;
                        r_mask      <= w_req_mask;
                        r_try       <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (req_bound <= OUT_W'(1)) begin
                            r_value     <= '0;
                            r_fallback  <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (rand_valid) begin
                        if (w_hit) begin
                            r_value     <= w_cand;
                            r_fallback  <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_last) begin
                            // cand < 2*bound, so one subtract lands in range
                            r_value     <= w_diff;
                            r_fallback  <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_try <= r_try + TRY_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_value    = r_value;
    assign rsp_fallback = r_fallback;
    assign busy         = r_busy;

endmodule

// File: tb/tb_rand_range_picker.sv
// Directed and LFSR-soak bench for rand_range_picker.
// Inputs driven and outputs sampled on the falling edge.
module tb_rand_range_picker;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rand_in;
    logic        rand_valid;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_bound;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_value;
    logic        rsp_fallback;
    logic        busy;

    int total = 0;
    int bad   = 0;

    rand_range_picker dut (
        .clk          (clk),
        .rst          (rst),
        .rand_in      (rand_in),
        .rand_valid   (rand_valid),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bound    (req_bound),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_value    (rsp_value),
        .rsp_fallback (rsp_fallback),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [7:0] b);
        req_valid = 1'b1;
        req_bound = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_bound = 8'hAA;
    endtask

    task automatic draw(input logic [15:0] w);
        rand_valid = 1'b1;
        rand_in    = w;
        @(negedge clk);
        rand_valid = 1'b0;
        rand_in    = 16'h0000;
    endtask

    task automatic take(input string tag,
                        input logic [7:0] v,
                        input logic fb);
        check({tag, "_vld"}, rsp_valid, 1'b1);
        check({tag, "_val"}, rsp_value, v);
        check({tag, "_fb"}, rsp_fallback, fb);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_idle"}, {rsp_valid, req_ready, busy}, 3'b010);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lfsr;
        logic [7:0]  b;
        int          cnt;

        rst        = 1'b0;
        rand_in    = 16'h0;
        rand_valid = 1'b0;
        req_valid  = 1'b0;
        req_bound  = 8'h0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("reset", {rsp_valid, req_ready, busy, rsp_fallback}, 4'b0100);
        check("reset_val", rsp_value, 8'h00);

        // basic hit
        req(8'd4);
        check("hit_wait", {rsp_valid, req_ready, busy}, 3'b001);
        draw(16'h1236);
        take("hit", 8'd2, 1'b0);

        // two rejections then hit
        req(8'd5);
        draw(16'h0007);
        check("rej1", rsp_valid, 1'b0);
        draw(16'h0006);
        check("rej2", rsp_valid, 1'b0);
        draw(16'h0003);
        take("rej_hit", 8'd3, 1'b0);

        // fallback after four misses
        req(8'd5);
        repeat (3) draw(16'h00FF);
        check("fb_pend", rsp_valid, 1'b0);
        draw(16'h00FF);
        take("fb", 8'd2, 1'b1);

        // degenerate bounds
        req(8'd0);
        take("b0", 8'd0, 1'b0);
        req(8'd1);
        take("b1", 8'd0, 1'b0);
        req(8'd255);
        draw(16'h00FF);
        check("b255_rej", rsp_valid, 1'b0);
        draw(16'h12FE);
        take("b255", 8'd254, 1'b0);

        // backpressure
        req(8'd4);
        draw(16'h0001);
        for (int i = 0; i < 5; i++) begin
            check("bp_val", rsp_value, 8'd1);
            check("bp_rdy", {rsp_valid, req_ready}, 2'b10);
            @(negedge clk);
        end
        take("bp", 8'd1, 1'b0);

        // stall in DRAW keeps the try count
        req(8'd5);
        draw(16'h0007);
        draw(16'h0007);
        @(negedge clk);
        check("stall", {rsp_valid, busy}, 2'b01);
        draw(16'h0007);
        check("stall_try", rsp_valid, 1'b0);
        draw(16'h0007);
        take("stall_fb", 8'd2, 1'b1);

        // reset mid-DRAW
        req(8'd5);
        draw(16'h0007);
        rst        = 1'b0;
        rand_valid = 1'b1;
        rand_in    = 16'h0003;
        @(negedge clk);
        rst        = 1'b1;
        rand_valid = 1'b0;
        check("mid_rst", {rsp_valid, req_ready, busy, rsp_fallback}, 4'b0100);
        check("mid_rst_val", rsp_value, 8'h00);
        rand_valid = 1'b1;
        repeat (3) @(negedge clk);
        rand_valid = 1'b0;
        check("mid_rst_quiet", {rsp_valid, busy}, 2'b00);
        req(8'd4);
        draw(16'h0003);
        take("post_rst", 8'd3, 1'b0);

        // soak with LFSR source
        lfsr = 16'hACE1;
        for (int n = 0; n < 10000; n++) begin
            b = 8'($urandom_range(1, 200));
            req(b);
            cnt = 0;
            while (!rsp_valid && cnt < 20) begin
                lfsr       = lfsr_step(lfsr);
                rand_in    = lfsr;
                rand_valid = 1'b1;
                @(negedge clk);
                cnt++;
            end
            rand_valid = 1'b0;
            check("soak_lat", (cnt <= 4), 1'b1);
            check("soak_rng", (rsp_valid && rsp_value < b), 1'b1);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rand_range_picker.md
Name: rand_range_picker

Overview:
- Consumes the free-running 16-bit pseudo-random word from the LFSR stage. Converts it into an unbiased integer in [0, bound-1] on request.
- Uses rejection sampling, with a bounded retry count and a deterministic fallback.
- Serves the game logic, e.g. enemy direction choice (bound 4) and power-up drop and placement (bound = tile count).
- One request in flight at a time, with valid/ready handshakes on both sides.

Parameters:
- RAND_W, 16: width of the incoming random word.
- OUT_W, 8: width of the bound and the result. Must satisfy OUT_W <= RAND_W.
- MAX_TRIES, 4: number of draws attempted before the fallback is used. Must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset. Asserted when 0, sampled on posedge clk.
- rand_in  input  RAND_W  random word from the LFSR stage.
- rand_valid  input  1  rand_in holds a fresh word this cycle.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_bound  input  OUT_W  exclusive upper bound of the requested range.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_value  output  OUT_W  result, always < bound (0 when bound <= 1).
- rsp_fallback  output  1  result came from the fallback path.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst == 0 at posedge): state = IDLE.
  - rsp_valid = 0, rsp_value = 0, rsp_fallback = 0, req_ready = 1, busy = 0.
  - try counter = 0; latched bound and mask = 0.
- Reset mid-operation abandons the request silently. No response is ever issued for it.
- FSM states: IDLE, DRAW, DONE. req_ready = (state == IDLE), registered.
- IDLE, on handshake (req_valid && req_ready):
  - Latch bound.
  - mask = smallest 2^k-1 >= bound-1, i.e. right-fill of (bound-1).
  - Clear the try counter.
  - If bound is 0 or 1: go to DONE with rsp_value = 0, rsp_fallback = 0. Otherwise go to DRAW.
- DRAW, on a cycle with rand_valid = 1:
  - cand = rand_in[OUT_W-1:0] & mask.
  - If cand < bound: rsp_value = cand, rsp_fallback = 0, go to DONE.
  - Else, if try == MAX_TRIES-1: rsp_value = cand - bound, rsp_fallback = 1, go to DONE. This is always < bound, because cand < 2*bound.
  - Else: try increments and the block stays in DRAW.
- DRAW with rand_valid = 0: stall; the try counter is unchanged.
- DONE: rsp_valid = 1.
  - rsp_value and rsp_fallback are held stable until rsp_ready = 1.
  - On that edge: rsp_valid = 0, go to IDLE.
- Latency: request accepted at edge T. The first draw samples rand_in at edge T+1.
  - Best case, rsp_valid is high after edge T+1.
  - Worst case without stalls, after edge T+MAX_TRIES.
- Throughput: rsp_valid and req_ready are never high together. Back-to-back requests need at least 3 cycles each.
- req_bound is sampled only at the handshake. Later changes are ignored.
- All arithmetic is unsigned at OUT_W bits. The compare and subtract use the latched bound.

Decomposition:
- Package rand_pkg holds:
  - the state enum (IDLE, DRAW, DONE);
  - the function range_mask(bound) returning the right-filled mask of bound-1;
  - default constants RAND_W = 16, OUT_W = 8, MAX_TRIES = 4.
- No sub-module is needed. The datapath (mask, compare, subtract) is combinational inside the FSM module.
- Bench convenience: wrap it with the LFSR stage as the rand_in source for a soak test.

Test Plan:
- Basic hit: bound=4, next rand_in=16'h1236 with rand_valid=1.
  - Expect rsp_value=2, rsp_fallback=0, rsp_valid high one cycle after the draw edge.
- Rejection then hit: bound=5 (mask 7).
  - Draws with low bytes 8'h07, 8'h06, 8'h03: expect two rejections, then rsp_value=3 on the third draw.
- Fallback: bound=5, MAX_TRIES=4, four draws with low bits 3'b111.
  - Expect rsp_value=2, rsp_fallback=1.
- Degenerate bounds:
  - bound=0 gives rsp_value=0 with no draw consumed.
  - bound=1 gives the same.
  - bound=255 (mask 255): rand low byte 8'hFF rejects, 8'hFE gives 254.
- Backpressure and stall:
  - Hold rsp_ready=0 for 5 cycles: rsp_value is stable and req_ready stays 0.
  - rand_valid=0 in DRAW holds the state and the try counter.
- Reset mid-DRAW: assert rst=0 for one cycle during DRAW.
  - Expect all outputs at reset values and no rsp_valid.
  - The next request completes normally.
- Soak with the LFSR source: 10k requests with random bound in 1..200.
  - Every rsp_value < bound.
